gpioemu_shmul: RTL

Parametrised successor of the GPIO-emulator arithmetic peripheral, mapped on the same saddress/srd/swr/sdata bus. Software loads A1 and A2 and writes START. The block then computes W = A1·2^A2, truncated to DATA_W, with an exact overflow flag, and computes L = popcount(W) iteratively. It exposes status, result and a completed-operation counter, which is also driven on gpio_out. Unlike the previous generation, everything runs on clk: bus strobes are edge-detected, and busy, done and error status is explicit.

---
 rtl/gpioemu_pkg.sv | 39 +++
 rtl/gpioemu_popcnt_seq.sv | 49 ++++
 rtl/gpioemu_shmul.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gpioemu_pkg.sv
// Shared types, CS bit positions, default bus addresses and slice popcount
// for the GPIO-emulator shift/multiply peripheral.
package gpioemu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_POPCNT,
      ST_DONE
   } state_t;

   // Control bits (write) and status bits (read) of the CS register
   localparam int unsigned CS_START = 0;
   localparam int unsigned CS_CLR   = 1;
   localparam int unsigned CS_BUSY  = 0;
   localparam int unsigned CS_DONE  = 1;
   localparam int unsigned CS_OVF   = 2;
   localparam int unsigned CS_ERR   = 3;

   localparam logic [15:0] ADDR_A1_DEF = 16'h037F;
   localparam logic [15:0] ADDR_A2_DEF = 16'h0388;
   localparam logic [15:0] ADDR_W_DEF  = 16'h0390;
   localparam logic [15:0] ADDR_L_DEF  = 16'h0398;
   localparam logic [15:0] ADDR_CS_DEF = 16'h03A0;

   localparam int unsigned POP_MAX_W = 32;
   localparam int unsigned POP_CNT_W = 6;

   // Callers zero-extend their POP_BPC-wide slice to POP_MAX_W
   function automatic logic [POP_CNT_W-1:0] popcount_slice(input logic [POP_MAX_W-1:0] s);
      logic [POP_CNT_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < POP_MAX_W; i++) begin
         n = n + POP_CNT_W'(s[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gpioemu_popcnt_seq.sv
// Iterative popcount: consumes POP_BPC bits per cycle, DATA_W/POP_BPC cycles per word.
module gpioemu_popcnt_seq
   import gpioemu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned POP_BPC = 4
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic                          start,
   input  logic [DATA_W-1:0]             data,
   output logic                          busy,
   output logic                          done_c,
   output logic [$clog2(DATA_W+1)-1:0]   count
);

   localparam int unsigned STEPS = DATA_W / POP_BPC;
   localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int unsigned CW    = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] data_q;
   logic [IDX_W-1:0]  idx;

   // High during the cycle in which the final slice is accumulated
   assign done_c = busy && (idx == IDX_W'(STEPS - 1));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         data_q <= '0;
         idx    <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         data_q <= data;
         idx    <= '0;
         count  <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         count  <= count + CW'(popcount_slice(POP_MAX_W'(data_q[POP_BPC-1:0])));
         data_q <= data_q >> POP_BPC;
         if (done_c) begin
            busy <= 1'b0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpioemu_shmul.sv
// GPIO-emulator arithmetic peripheral: W = A1*2^A2 (truncated, exact overflow flag),
// L = popcount(W), completed-operation counter on gpio_out.
module gpioemu_shmul
   import gpioemu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ARG_W   = 24,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned POP_BPC = 4,
   parameter logic [15:0] ADDR_A1 = ADDR_A1_DEF,
   parameter logic [15:0] ADDR_A2 = ADDR_A2_DEF,
   parameter logic [15:0] ADDR_W  = ADDR_W_DEF,
   parameter logic [15:0] ADDR_L  = ADDR_L_DEF,
   parameter logic [15:0] ADDR_CS = ADDR_CS_DEF
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [15:0]       saddress,
   input  logic              srd,
   input  logic              swr,
   input  logic [DATA_W-1:0] sdata_in,
   output logic [DATA_W-1:0] sdata_out,
   input  logic [DATA_W-1:0] gpio_in,
   input  logic              gpio_latch,
   output logic [DATA_W-1:0] gpio_in_s_insp,
   output logic [DATA_W-1:0] gpio_out
);

   localparam int unsigned SH_W  = $clog2(DATA_W);
   localparam int unsigned EXT_W = DATA_W + ARG_W;
   localparam int unsigned PC_W  = $clog2(DATA_W + 1);

   state_t             state;
   logic               srd_q, swr_q, rd_edge, wr_edge, start_req, clr_req;
   logic [ARG_W-1:0]   a1, a2, a1_s, a2_s;
   logic [DATA_W-1:0]  wtmp, w_r, l_r, shift_w, rd_data;
   logic [EXT_W-1:0]   ext;
   logic               shift_ovf, ovf_tmp, ovf, done, busy, err;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         status;
   logic               pc_start, pc_busy, pc_done_c;
   logic [PC_W-1:0]    pc_count;
   logic               unused_bits;

   assign unused_bits = ^sdata_in;

   assign rd_edge   = srd && !srd_q;
   assign wr_edge   = swr && !swr_q;
   assign start_req = wr_edge && (saddress == ADDR_CS) && sdata_in[CS_START];
   assign clr_req   = wr_edge && (saddress == ADDR_CS) && sdata_in[CS_CLR];
   assign pc_start  = (state == ST_SHIFT);
   assign gpio_out  = DATA_W'(cnt);

   // Bus strobes, operand registers and gpio capture
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         srd_q          <= 1'b0;
         swr_q          <= 1'b0;
         a1             <= '0;
         a2             <= '0;
         gpio_in_s_insp <= '0;
         sdata_out      <= '0;
      end else begin
         srd_q <= srd;
         swr_q <= swr;
         if (wr_edge && (saddress == ADDR_A1)) a1 <= sdata_in[ARG_W-1:0];
         if (wr_edge && (saddress == ADDR_A2)) a2 <= sdata_in[ARG_W-1:0];
         if (gpio_latch) gpio_in_s_insp <= gpio_in;
         if (rd_edge) sdata_out <= rd_data;
      end
   end

   always_comb begin
      status          = '0;
      status[CS_BUSY] = busy;
      status[CS_DONE] = done;
      status[CS_OVF]  = ovf;
      status[CS_ERR]  = err;
      case (saddress)
         ADDR_A1: rd_data = DATA_W'(a1);
         ADDR_A2: rd_data = DATA_W'(a2);
         ADDR_W:  rd_data = w_r;
         ADDR_L:  rd_data = l_r;
         ADDR_CS: rd_data = DATA_W'(status);
         default: rd_data = '0;
      endcase
   end

   // Overflow is exact: any set A1 bit landing at or above bit DATA_W
   always_comb begin
      ext = EXT_W'(a1_s) << a2_s[SH_W-1:0];
      if (a2_s >= ARG_W'(DATA_W)) begin
         shift_w   = '0;
         shift_ovf = |a1_s;
      end else begin
         shift_w   = ext[DATA_W-1:0];
         shift_ovf = |ext[EXT_W-1:DATA_W];
      end
   end

   gpioemu_popcnt_seq #(
      .DATA_W  (DATA_W),
      .POP_BPC (POP_BPC)
   ) u_popcnt (
      .clk     (clk),
      .n_reset (n_reset),
      .start   (pc_start),
      .data    (shift_w),
      .busy    (pc_busy),
      .done_c  (pc_done_c),
      .count   (pc_count)
   );

   // Operation FSM; CLR is applied after DONE so it wins, START errors when not idle
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= ST_IDLE;
         a1_s    <= '0;
         a2_s    <= '0;
         wtmp    <= '0;
         ovf_tmp <= 1'b0;
         w_r     <= '0;
         l_r     <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  a1_s  <= a1;
                  a2_s  <= a2;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               wtmp    <= shift_w;
               ovf_tmp <= shift_ovf;
               state   <= ST_POPCNT;
            end
            ST_POPCNT: begin
               if (pc_done_c || !pc_busy) state <= ST_DONE;
            end
            ST_DONE: begin
               w_r   <= wtmp;
               l_r   <= DATA_W'(pc_count);
               ovf   <= ovf_tmp;
               done  <= 1'b1;
               busy  <= 1'b0;
               cnt   <= cnt + CNT_W'(1);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (clr_req) begin
            done <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
         end
         if (start_req && (state != ST_IDLE)) err <= 1'b1;
      end
   end

endmodule
